// File: rtl/riscv_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// The arbiter honours RISCV_ARB_POSTED_WR_EN for posted writes.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/riscv_arb_timer.sv
// Loadable down-counter; expired is high while enabled at zero.
// Used as the grant/response watchdog of the memory arbiter.
module riscv_arb_timer #(
  parameter int unsigned W = 8
) (
  input  logic         I_clk,
  input  logic         I_rst,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port arbiter for fetch and data; data wins (older insn).
// Define RISCV_ARB_POSTED_WR_EN to complete writes on grant.
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          I_clk,
  input  logic          I_rst,
  input  logic          I_ireq,
  input  logic [AW-1:0] I_iaddr,
  output logic [31:0]   O_idata,
  output logic          O_ivalid,
  input  logic          I_dreq,
  input  logic          I_dwe,
  input  logic [AW-1:0] I_daddr,
  input  logic [31:0]   I_dwdata,
  input  logic [3:0]    I_dwmask,
  output logic [31:0]   O_drdata,
  output logic          O_dvalid,
  output logic          O_stall,
  output logic          O_err,
  output logic          O_mem_req,
  output logic          O_mem_we,
  output logic [AW-1:0] O_mem_addr,
  output logic [31:0]   O_mem_wdata,
  output logic [3:0]    O_mem_wmask,
  input  logic          I_mem_gnt,
  input  logic          I_mem_rvalid,
  input  logic [31:0]   I_mem_rdata
);

`ifdef RISCV_ARB_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] TLOAD =
    TMO_EN ? TW'(TIMEOUT - 1) : '0;

  arb_state_t state_q, state_d;
  req_id_t    act_q;

  logic i_served, d_served;
  logic ipend, dpend;
  logic expired, tmo, fin;
  logic tmr_ld, tmr_en;

  assign ipend   = I_ireq & ~i_served;
  assign dpend   = I_dreq & ~d_served;
  assign O_stall = ipend | dpend;

  assign tmr_ld = (state_d != state_q);
  assign tmr_en = TMO_EN &&
                  (state_q == REQ || state_q == RESP);

  riscv_arb_timer #(
    .W(TW)
  ) u_timer (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .ld      (tmr_ld),
    .en      (tmr_en),
    .load_val(TLOAD),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ipend || dpend) state_d = REQ;
      end
      REQ: begin
        if (I_mem_gnt) begin
          state_d = (O_mem_we && POSTED) ? DONE : RESP;
        end else if (expired) begin
          state_d = DONE;
          tmo     = 1'b1;
        end
      end
      RESP: begin
        if (I_mem_rvalid) begin
          state_d = DONE;
        end else if (expired) begin
          state_d = DONE;
          tmo     = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fin = (state_d == DONE);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= IDLE;
      act_q       <= REQ_I;
      i_served    <= 1'b0;
      d_served    <= 1'b0;
      O_idata     <= '0;
      O_drdata    <= '0;
      O_ivalid    <= 1'b0;
      O_dvalid    <= 1'b0;
      O_err       <= 1'b0;
      O_mem_req   <= 1'b0;
      O_mem_we    <= 1'b0;
      O_mem_addr  <= '0;
      O_mem_wdata <= '0;
      O_mem_wmask <= '0;
    end else begin
      state_q  <= state_d;
      O_ivalid <= fin && (act_q == REQ_I);
      O_dvalid <= fin && (act_q == REQ_D);
      O_err    <= tmo;
      // Core advances: next cycle's requests are all new.
      if (!O_stall) begin
        i_served <= 1'b0;
        d_served <= 1'b0;
      end
      if (state_q == IDLE && dpend) begin
        act_q       <= REQ_D;
        O_mem_req   <= 1'b1;
        O_mem_we    <= I_dwe;
        O_mem_addr  <= I_daddr;
        O_mem_wdata <= I_dwdata;
        O_mem_wmask <= I_dwe ? I_dwmask : 4'b0000;
      end else if (state_q == IDLE && ipend) begin
        act_q       <= REQ_I;
        O_mem_req   <= 1'b1;
        O_mem_we    <= 1'b0;
        O_mem_addr  <= I_iaddr;
        O_mem_wdata <= '0;
        O_mem_wmask <= 4'b0000;
      end
      if (state_q == REQ && state_d != REQ) begin
        O_mem_req <= 1'b0;
      end
      if (fin) begin
        if (act_q == REQ_I) begin
          i_served <= 1'b1;
          O_idata  <= tmo ? '0 : I_mem_rdata;
        end else begin
          d_served <= 1'b1;
          if (tmo) begin
            O_drdata <= '0;
          end else if (state_q == RESP && !O_mem_we) begin
            O_drdata <= I_mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed plus random
// core cycles against a transaction-level model and bench memory.
module tb_riscv_mem_arbiter;

`ifdef RISCV_ARB_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam int TMO = 4;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  wm;
  } txn_t;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_ireq;
  logic [31:0] I_iaddr;
  logic [31:0] O_idata;
  logic        O_ivalid;
  logic        I_dreq;
  logic        I_dwe;
  logic [31:0] I_daddr;
  logic [31:0] I_dwdata;
  logic [3:0]  I_dwmask;
  logic [31:0] O_drdata;
  logic        O_dvalid;
  logic        O_stall;
  logic        O_err;
  logic        O_mem_req;
  logic        O_mem_we;
  logic [31:0] O_mem_addr;
  logic [31:0] O_mem_wdata;
  logic [3:0]  O_mem_wmask;
  logic        I_mem_gnt = 1'b0;
  logic        I_mem_rvalid = 1'b0;
  logic [31:0] I_mem_rdata = '0;

  riscv_mem_arbiter #(
    .AW(32),
    .TIMEOUT(TMO)
  ) dut (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_ireq      (I_ireq),
    .I_iaddr     (I_iaddr),
    .O_idata     (O_idata),
    .O_ivalid    (O_ivalid),
    .I_dreq      (I_dreq),
    .I_dwe       (I_dwe),
    .I_daddr     (I_daddr),
    .I_dwdata    (I_dwdata),
    .I_dwmask    (I_dwmask),
    .O_drdata    (O_drdata),
    .O_dvalid    (O_dvalid),
    .O_stall     (O_stall),
    .O_err       (O_err),
    .O_mem_req   (O_mem_req),
    .O_mem_we    (O_mem_we),
    .O_mem_addr  (O_mem_addr),
    .O_mem_wdata (O_mem_wdata),
    .O_mem_wmask (O_mem_wmask),
    .I_mem_gnt   (I_mem_gnt),
    .I_mem_rvalid(I_mem_rvalid),
    .I_mem_rdata (I_mem_rdata)
  );

  always #5 I_clk = ~I_clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cfg_gd = 0;
  int cfg_rd = 0;
  bit cfg_gb = 1'b0;
  bit cfg_rb = 1'b0;
  bit stray  = 1'b0;

  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] shadow    [logic [31:0]];
  txn_t        log_mem [64];
  int          log_wr = 0;
  int          log_rd = 0;
  int          unstable_n = 0;
  logic [31:0] exp_idata = '0;
  logic [31:0] exp_drdata = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] store_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  // Bench memory: grant after cfg_gd waits, respond after cfg_rd.
  int          age = 0;
  int          rcnt = 0;
  bit          rpend = 1'b0;
  logic [31:0] rdat = '0;
  txn_t        prev = '0;
  txn_t        cur;

  always begin
    @(negedge I_clk);
    #1;
    I_mem_gnt    = 1'b0;
    I_mem_rvalid = 1'b0;
    if (I_rst) begin
      age   = 0;
      rpend = 1'b0;
    end else begin
      if (stray) begin
        I_mem_rvalid = 1'b1;
        I_mem_rdata  = $urandom;
      end
      if (rpend) begin
        if (rcnt == 0) begin
          I_mem_rvalid = 1'b1;
          I_mem_rdata  = rdat;
          rpend        = 1'b0;
        end else begin
          rcnt--;
        end
      end
      if (O_mem_req) begin
        cur = '{O_mem_addr, O_mem_we, O_mem_wdata, O_mem_wmask};
        if (age > 0 && cur !== prev) unstable_n++;
        prev = cur;
        if (!cfg_gb && age == cfg_gd) begin
          I_mem_gnt = 1'b1;
          age = 0;
          log_mem[log_wr % 64] = cur;
          log_wr++;
          if (O_mem_we)
            mem_store[O_mem_addr] =
              merge(store_rd(O_mem_addr), O_mem_wdata, O_mem_wmask);
          if (!(O_mem_we && POSTED) && !cfg_rb) begin
            rpend = 1'b1;
            rcnt  = cfg_rd;
            rdat  = O_mem_we ? $urandom : store_rd(O_mem_addr);
          end
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
      input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_txn(input string tag, input logic [31:0] a,
      input logic w, input logic [31:0] wd, input logic [3:0] m);
    txn_t t;
    chk({tag, "_present"}, 32'(log_wr > log_rd), 32'd1);
    if (log_wr > log_rd) begin
      t = log_mem[log_rd % 64];
      log_rd++;
      chk({tag, "_addr"}, t.a, a);
      chk({tag, "_we"}, 32'(t.we), 32'(w));
      chk({tag, "_mask"}, 32'(t.wm), 32'(m));
      if (w) chk({tag, "_wdata"}, t.wd, wd);
    end
  endtask

  // One core cycle: present requests, run until stall drops, check.
  task automatic core_cycle(input bit di, input logic [31:0] ia,
      input bit dd, input bit we, input logic [31:0] da,
      input logic [31:0] wd, input logic [3:0] wm,
      input int gd, input int rd, input bit gb, input bit rb);
    int ld, li, n, j;
    int iv_n, dv_n, er_n, er_bad, iv_at, dv_at, uns0;
    bit need_r, tmo_d, tmo_i;
    need_r = !(we && POSTED);
    tmo_d  = gb || (rb && need_r);
    tmo_i  = gb || rb;
    ld = 0;
    li = 0;
    if (dd)
      ld = 2 + (gb ? TMO : gd + 1) +
           ((need_r && !gb) ? (rb ? TMO : rd + 1) : 0);
    if (di)
      li = 2 + (gb ? TMO : gd + 1) +
           (gb ? 0 : (rb ? TMO : rd + 1));
    n = ld + li - 1;
    if (dd) begin
      if (tmo_d) exp_drdata = '0;
      else if (!we) exp_drdata = shadow_rd(da);
      if (we && !gb) shadow[da] = merge(shadow_rd(da), wd, wm);
    end
    if (di) exp_idata = tmo_i ? '0 : shadow_rd(ia);
    cfg_gd = gd;
    cfg_rd = rd;
    cfg_gb = gb;
    cfg_rb = rb;
    uns0 = unstable_n;
    I_ireq   = di;
    I_iaddr  = ia;
    I_dreq   = dd;
    I_dwe    = we;
    I_daddr  = da;
    I_dwdata = wd;
    I_dwmask = wm;
    #1;
    chk("stall_c0", 32'(O_stall), 32'(di | dd));
    j = 0;
    iv_n = 0; dv_n = 0; er_n = 0; er_bad = 0;
    iv_at = -1; dv_at = -1;
    do begin
      @(negedge I_clk);
      j++;
      if (O_ivalid) begin iv_n++; iv_at = j; end
      if (O_dvalid) begin dv_n++; dv_at = j; end
      if (O_err) begin
        er_n++;
        if (!(O_ivalid || O_dvalid)) er_bad++;
      end
    end while (O_stall && j < 100);
    chk("stall_len", j, n);
    chk("dvalid_n", dv_n, dd ? 1 : 0);
    chk("ivalid_n", iv_n, di ? 1 : 0);
    if (dd) chk("dvalid_at", dv_at, ld - 1);
    if (di) chk("ivalid_at", iv_at, ld + li - 1);
    chk("err_n", er_n, (dd && tmo_d ? 1 : 0) + (di && tmo_i ? 1 : 0));
    chk("err_alone", er_bad, 0);
    chk("idata", O_idata, exp_idata);
    chk("drdata", O_drdata, exp_drdata);
    chk("mem_stable", unstable_n - uns0, 0);
    if (!gb) begin
      if (dd) check_txn("txn_d", da, we, wd, we ? wm : 4'b0000);
      if (di) check_txn("txn_i", ia, 1'b0, 32'h0, 4'b0000);
    end
    chk("txn_extra", log_wr - log_rd, 0);
  endtask

  task automatic gap();
    I_ireq = 1'b0;
    I_dreq = 1'b0;
    @(negedge I_clk);
    chk("stall_idle", 32'(O_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          di, dd, we;
    logic [31:0] ia, da;
    I_rst = 1'b1;
    I_ireq = 1'b0; I_iaddr = '0;
    I_dreq = 1'b0; I_dwe = 1'b0; I_daddr = '0;
    I_dwdata = '0; I_dwmask = '0;
    mem_store[32'h100] = 32'h0000_0013;
    shadow[32'h100]    = 32'h0000_0013;
    repeat (2) @(negedge I_clk);
    chk("rst_mem_req", 32'(O_mem_req), 32'd0);
    chk("rst_valids", {O_ivalid, O_dvalid, O_err}, 32'd0);
    chk("rst_idata", O_idata, 32'h0);
    chk("rst_stall_idle", 32'(O_stall), 32'd0);
    I_ireq = 1'b1;
    #1;
    chk("rst_stall_req", 32'(O_stall), 32'd1);
    I_ireq = 1'b0;
    @(negedge I_clk);
    I_rst = 1'b0;

    // Fetch only, earliest grant and response.
    core_cycle(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_word", O_idata, 32'h0000_0013);
    gap();
    // Fetch and data read together: data first.
    core_cycle(1, 32'h104, 1, 0, 32'h2000, 0, 0, 0, 0, 0, 0);
    gap();
    // Write with two grant wait cycles.
    core_cycle(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 4'b0011,
               2, 0, 0, 0);
    gap();
    core_cycle(0, 0, 1, 0, 32'h2004, 0, 0, 1, 1, 0, 0);
    gap();
    // Response never arrives, then grant never arrives.
    core_cycle(0, 0, 1, 0, 32'h2008, 0, 0, 0, 0, 0, 1);
    gap();
    core_cycle(1, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    gap();
    core_cycle(1, 32'h10C, 1, 0, 32'h200C, 0, 0, 0, 0, 1, 0);
    gap();
    // Back-to-back core cycles with the fetch held.
    core_cycle(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    I_iaddr = 32'h204;
    #1;
    chk("b2b_gap_stall", 32'(O_stall), 32'd0);
    @(negedge I_clk);
    chk("b2b_flags_clear", 32'(O_stall), 32'd1);
    core_cycle(1, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    gap();

    // Reset while waiting in RESP, then a stray response.
    cfg_gd = 0; cfg_rd = 2; cfg_gb = 0; cfg_rb = 0;
    I_dreq = 1'b1; I_dwe = 1'b0; I_daddr = 32'h2010;
    repeat (2) @(negedge I_clk);
    I_rst = 1'b1;
    #1;
    exp_idata = '0;
    exp_drdata = '0;
    chk("arst_mem_req", 32'(O_mem_req), 32'd0);
    chk("arst_stall", 32'(O_stall), 32'd1);
    chk("arst_idata", O_idata, 32'h0);
    chk("arst_drdata", O_drdata, 32'h0);
    check_txn("arst_txn", 32'h2010, 1'b0, 32'h0, 4'b0000);
    I_dreq = 1'b0;
    @(negedge I_clk);
    I_rst = 1'b0;
    stray = 1'b1;
    @(negedge I_clk);
    stray = 1'b0;
    begin
      int hits;
      hits = 0;
      repeat (4) begin
        @(negedge I_clk);
        if (O_ivalid || O_dvalid || O_err || O_mem_req) hits++;
      end
      chk("arst_stray_ignored", hits, 0);
    end
    chk("arst_txn_none", log_wr - log_rd, 0);

    // Random core cycles.
    for (int k = 0; k < 24; k++) begin
      di = 1'($urandom_range(0, 1));
      dd = 1'($urandom_range(0, 1));
      if (!di && !dd) di = 1'b1;
      we = 1'($urandom_range(0, 1));
      ia = 32'h100 + 32'(4 * $urandom_range(0, 15));
      da = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      core_cycle(di, ia, dd, we, da, $urandom,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
      gap();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
